efuse_shadow_loader: RTL and testbench

- Sits directly downstream of the eFuse controller.
- Consumes the byte stream produced during autoload (vld/data/done) and assembles it into a 256-bit shadow register.
- Validates the stream with a byte-count check and an XOR checksum, then drives the trim bus for analog/PMU consumers.
- Provides a register-driven override path and a software clear.

---
 rtl/efuse_shadow_loader.sv | 229 ++++++++++++++++++++++
 tb/tb_efuse_shadow_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/efuse_shadow_loader.sv
`default_nettype none
// ============================================================================
//  Module      : efuse_shadow_loader
//  Description : Assembles the eFuse autoload byte stream into a shadow
//                register, validates it with a byte count and XOR checksum,
//                and drives the registered trim bus. Supports a register
//                override of the trim bus and a software clear.
//
//  Ports:
//    clk                  system clock
//    rst                  asynchronous active-high reset
//    efuse_autoload_vld   one-cycle strobe, efuse_autoload_data valid
//    efuse_autoload_data  autoload byte, ascending address order
//    efuse_autoload_done  one-cycle strobe, autoload sequence finished
//    rg_shadow_clr        one-cycle strobe, clear shadow and flags
//    rg_ovr_en            select rg_ovr_data onto trim bus
//    rg_ovr_data          override trim value
//    trim_data            registered trim bus to consumers
//    trim_valid           shadow loaded and checksum good
//    chk_err              checksum mismatch on last load
//    cnt_err              byte count != NB on last load
//    load_cnt             bytes accepted in current/last load (sat. at 63)
//    shadow_busy          high while loading or checking
//
//  Revision    : 1.0 - initial release
// ============================================================================
module efuse_shadow_loader #(
    parameter int          NB       = 32,
    parameter logic [7:0]  CHK_SEED = 8'hA5,
    parameter int          TW       = 8 * NB
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          efuse_autoload_vld,
    input  logic [7:0]    efuse_autoload_data,
    input  logic          efuse_autoload_done,
    input  logic          rg_shadow_clr,
    input  logic          rg_ovr_en,
    input  logic [TW-1:0] rg_ovr_data,
    output logic [TW-1:0] trim_data,
    output logic          trim_valid,
    output logic          chk_err,
    output logic          cnt_err,
    output logic [5:0]    load_cnt,
    output logic          shadow_busy
);

    // Pointer must be able to hold NB itself (one past the last byte).
    localparam int PW = $clog2(NB + 1);

    localparam logic [PW-1:0] c_PTR_NB   = PW'(NB);
    localparam logic [PW-1:0] c_PTR_LAST = PW'(NB - 1);
    localparam logic [PW-1:0] c_PTR_ONE  = PW'(1);
    localparam logic [5:0]    c_CNT_NB   = 6'(NB);
    localparam logic [5:0]    c_CNT_MAX  = 6'd63;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LOAD  = 3'd1;
    localparam logic [2:0] c_ST_CHECK = 3'd2;
    localparam logic [2:0] c_ST_VALID = 3'd3;
    localparam logic [2:0] c_ST_ERR   = 3'd4;

    logic [2:0]    r_state,  w_state_nxt;
    logic [PW-1:0] r_ptr,    w_ptr_nxt;
    logic [5:0]    r_cnt,    w_cnt_nxt;
    logic [7:0]    r_chk,    w_chk_nxt;
    logic [7:0]    r_exp,    w_exp_nxt;
    logic          r_ovf,    w_ovf_nxt;
    logic          r_tv,     w_tv_nxt;
    logic          r_ce,     w_ce_nxt;
    logic          r_ne,     w_ne_nxt;
    logic [TW-1:0] r_trim;

    logic          w_wr_en;
    logic [PW-1:0] w_wr_idx;
    logic [TW-1:0] w_shadow_flat;
    logic          w_cnt_bad;
    logic          w_chk_bad;

    // ------------------------------------------------------------------------
    // Next-state / datapath control
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_chk_nxt   = r_chk;
        w_exp_nxt   = r_exp;
        w_ovf_nxt   = r_ovf;
        w_tv_nxt    = r_tv;
        w_ce_nxt    = r_ce;
        w_ne_nxt    = r_ne;
        w_wr_en     = 1'b0;
        w_wr_idx    = r_ptr;
        w_cnt_bad   = (r_cnt != c_CNT_NB) || r_ovf;
        w_chk_bad   = !w_cnt_bad && (r_chk != r_exp);

        if (rg_shadow_clr) begin
            // Clear beats any simultaneous byte; that byte is lost.
            w_state_nxt = c_ST_IDLE;
            w_ptr_nxt   = '0;
            w_cnt_nxt   = '0;
            w_chk_nxt   = CHK_SEED;
            w_exp_nxt   = '0;
            w_ovf_nxt   = 1'b0;
            w_tv_nxt    = 1'b0;
            w_ce_nxt    = 1'b0;
            w_ne_nxt    = 1'b0;
        end else begin
            case (r_state)
                c_ST_LOAD: begin
                    if (efuse_autoload_vld) begin
                        if (r_ptr < c_PTR_NB) begin
                            w_wr_en   = 1'b1;
                            w_ptr_nxt = r_ptr + c_PTR_ONE;
                        end else begin
                            w_ovf_nxt = 1'b1;
                        end
                        if (r_ptr < c_PTR_LAST)
                            w_chk_nxt = r_chk ^ efuse_autoload_data;
                        if (r_ptr == c_PTR_LAST)
                            w_exp_nxt = efuse_autoload_data;
                        if (r_cnt != c_CNT_MAX)
                            w_cnt_nxt = r_cnt + 6'd1;
                    end
                    // A byte arriving with done has already been taken above.
                    if (efuse_autoload_done)
                        w_state_nxt = c_ST_CHECK;
                end

                default: begin
                    if (efuse_autoload_vld) begin
                        // Restart: the first byte lands at index 0 now, so the
                        // registered pointer/count already account for it.
                        // Index 0 is always a payload byte (NB >= 2).
                        w_state_nxt = efuse_autoload_done ? c_ST_CHECK : c_ST_LOAD;
                        w_wr_en     = 1'b1;
                        w_wr_idx    = '0;
                        w_ptr_nxt   = c_PTR_ONE;
                        w_cnt_nxt   = 6'd1;
                        w_chk_nxt   = CHK_SEED ^ efuse_autoload_data;
                        w_exp_nxt   = '0;
                        w_ovf_nxt   = 1'b0;
                        w_tv_nxt    = 1'b0;
                        w_ce_nxt    = 1'b0;
                        w_ne_nxt    = 1'b0;
                    end else if (r_state == c_ST_IDLE && efuse_autoload_done) begin
                        // A zero-byte load is a count error.
                        w_state_nxt = c_ST_ERR;
                        w_ne_nxt    = 1'b1;
                        w_ce_nxt    = 1'b0;
                        w_tv_nxt    = 1'b0;
                    end else if (r_state == c_ST_CHECK) begin
                        w_ne_nxt    = w_cnt_bad;
                        w_ce_nxt    = w_chk_bad;
                        w_tv_nxt    = !(w_cnt_bad || w_chk_bad);
                        w_state_nxt = (w_cnt_bad || w_chk_bad) ? c_ST_ERR : c_ST_VALID;
                    end else if (r_state > c_ST_ERR) begin
                        // Unreachable encodings recover to IDLE.
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Control registers and trim bus
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_chk   <= CHK_SEED;
            r_exp   <= '0;
            r_ovf   <= 1'b0;
            r_tv    <= 1'b0;
            r_ce    <= 1'b0;
            r_ne    <= 1'b0;
            r_trim  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_chk   <= w_chk_nxt;
            r_exp   <= w_exp_nxt;
            r_ovf   <= w_ovf_nxt;
            r_tv    <= w_tv_nxt;
            r_ce    <= w_ce_nxt;
            r_ne    <= w_ne_nxt;
            // Keyed on the next valid flag so data and valid rise together;
            // the shadow is stable in CHECK, so no partial data escapes.
            if (rg_ovr_en)
                r_trim <= rg_ovr_data;
            else if (w_tv_nxt)
                r_trim <= w_shadow_flat;
            else
                r_trim <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // Shadow byte storage
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < NB; gi++) begin : g_byte
        logic [7:0] r_byte;

        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                r_byte <= '0;
            else if (rg_shadow_clr)
                r_byte <= '0;
            else if (w_wr_en && (w_wr_idx == PW'(gi)))
                r_byte <= efuse_autoload_data;
        end

        assign w_shadow_flat[gi*8 +: 8] = r_byte;
    end

    assign trim_data   = r_trim;
    assign trim_valid  = r_tv;
    assign chk_err     = r_ce;
    assign cnt_err     = r_ne;
    assign load_cnt    = r_cnt;
    assign shadow_busy = (r_state == c_ST_LOAD) || (r_state == c_ST_CHECK);

endmodule
`default_nettype wire

// File: tb/tb_efuse_shadow_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_efuse_shadow_loader
//  Description : Self-checking bench for efuse_shadow_loader. Expected load
//                results are pushed to a scoreboard queue as each stream is
//                driven and popped when the DUT settles after done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_efuse_shadow_loader;

    localparam int NB = 32;
    localparam int TW = 256;

    typedef struct {
        logic          tv;
        logic          ce;
        logic          ne;
        logic [5:0]    cnt;
        logic [TW-1:0] trim;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          vld;
    logic [7:0]    data;
    logic          done;
    logic          clr;
    logic          ovr_en;
    logic [TW-1:0] ovr_data;
    logic [TW-1:0] trim_data;
    logic          trim_valid;
    logic          chk_err;
    logic          cnt_err;
    logic [5:0]    load_cnt;
    logic          shadow_busy;

    exp_t       sb[$];
    logic [7:0] stim [40];
    logic [7:0] m_sh [NB];
    int         n_checks = 0;
    int         n_pass   = 0;

    efuse_shadow_loader dut (
        .clk                 (clk),
        .rst                 (rst),
        .efuse_autoload_vld  (vld),
        .efuse_autoload_data (data),
        .efuse_autoload_done (done),
        .rg_shadow_clr       (clr),
        .rg_ovr_en           (ovr_en),
        .rg_ovr_data         (ovr_data),
        .trim_data           (trim_data),
        .trim_valid          (trim_valid),
        .chk_err             (chk_err),
        .cnt_err             (cnt_err),
        .load_cnt            (load_cnt),
        .shadow_busy         (shadow_busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [TW-1:0] shadow_flat();
        logic [TW-1:0] f;
        for (int i = 0; i < NB; i++) f[i*8 +: 8] = m_sh[i];
        return f;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NB; i++) m_sh[i] = 8'h00;
    endtask

    task automatic fill_ramp(input logic [7:0] last);
        for (int i = 0; i < 40; i++) stim[i] = 8'hFF;
        for (int i = 0; i < 31; i++) stim[i] = 8'(i);
        stim[31] = last;
    endtask

    task automatic fill_zero();
        for (int i = 0; i < 40; i++) stim[i] = 8'h00;
        stim[31] = 8'hA5;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic with_done);
        vld  = 1'b1;
        data = b;
        done = with_done;
        tick();
        vld  = 1'b0;
        done = 1'b0;
    endtask

    // Drive n bytes then done (optionally on the same cycle as the last byte),
    // predict the outcome, and compare two edges after done.
    task automatic run_load(input string tag, input int n, input logic done_with_last);
        int         cnt;
        logic [7:0] chk;
        logic [7:0] expb;
        exp_t       e;
        exp_t       got;
        cnt  = 0;
        chk  = 8'hA5;
        expb = 8'h00;
        for (int i = 0; i < n; i++) begin
            send_byte(stim[i], (done_with_last && i == n - 1) ? 1'b1 : 1'b0);
            if (i < NB)      m_sh[i] = stim[i];
            if (i <= NB - 2) chk = chk ^ stim[i];
            if (i == NB - 1) expb = stim[i];
            if (cnt < 63)    cnt++;
        end
        if (!done_with_last || n == 0) begin
            done = 1'b1;
            tick();
            done = 1'b0;
        end
        e.ne   = (cnt != NB);
        e.ce   = !e.ne && (chk != expb);
        e.tv   = !(e.ne || e.ce);
        e.cnt  = 6'(cnt);
        e.trim = e.tv ? shadow_flat() : '0;
        sb.push_back(e);
        if (n > 0) begin
            check_eq({tag, "_busy_chk"}, TW'(shadow_busy), TW'(1'b1));
            check_eq({tag, "_tv_early"}, TW'(trim_valid), TW'(1'b0));
        end
        tick();
        if (sb.size() == 0) begin
            check_eq({tag, "_sb_empty"}, TW'(0), TW'(1));
        end else begin
            got = sb.pop_front();
            check_eq({tag, "_trim_valid"}, TW'(trim_valid), TW'(got.tv));
            check_eq({tag, "_chk_err"},    TW'(chk_err),    TW'(got.ce));
            check_eq({tag, "_cnt_err"},    TW'(cnt_err),    TW'(got.ne));
            check_eq({tag, "_load_cnt"},   TW'(load_cnt),   TW'(got.cnt));
            check_eq({tag, "_trim_data"},  trim_data,       got.trim);
            check_eq({tag, "_busy_end"},   TW'(shadow_busy), TW'(1'b0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        vld      = 1'b0;
        data     = 8'h00;
        done     = 1'b0;
        clr      = 1'b0;
        ovr_en   = 1'b0;
        ovr_data = '0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_trim_data",  trim_data,        '0);
        check_eq("rst_trim_valid", TW'(trim_valid),  TW'(0));
        check_eq("rst_chk_err",    TW'(chk_err),     TW'(0));
        check_eq("rst_cnt_err",    TW'(cnt_err),     TW'(0));
        check_eq("rst_load_cnt",   TW'(load_cnt),    TW'(0));
        check_eq("rst_busy",       TW'(shadow_busy), TW'(0));
        rst = 1'b0;
        tick();

        // Zero-byte load: done while idle is a count error.
        run_load("empty", 0, 1'b0);

        // Good load.
        fill_ramp(8'hBA);
        run_load("good", 32, 1'b0);
        check_eq("good_b0",  TW'(trim_data[7:0]),     TW'(8'h00));
        check_eq("good_b30", TW'(trim_data[247:240]), TW'(8'h1E));
        check_eq("good_b31", TW'(trim_data[255:248]), TW'(8'hBA));

        // Bad checksum.
        fill_ramp(8'hBB);
        run_load("badchk", 32, 1'b0);

        // Short and long loads.
        fill_zero();
        run_load("short", 31, 1'b0);
        fill_ramp(8'hBA);
        run_load("long", 33, 1'b0);

        // Override path.
        fill_ramp(8'hBA);
        run_load("preovr", 32, 1'b0);
        ovr_data = {32{8'h5A}};
        ovr_en   = 1'b1;
        #1;
        check_eq("ovr_latency", trim_data, shadow_flat());
        tick();
        check_eq("ovr_on", trim_data, {32{8'h5A}});
        ovr_en = 1'b0;
        tick();
        check_eq("ovr_off", trim_data, shadow_flat());

        // Clear coinciding with byte 10.
        fill_ramp(8'hBA);
        for (int i = 0; i < 10; i++) send_byte(stim[i], 1'b0);
        vld  = 1'b1;
        data = stim[10];
        clr  = 1'b1;
        tick();
        vld = 1'b0;
        clr = 1'b0;
        clear_model();
        check_eq("clr_load_cnt", TW'(load_cnt),    TW'(0));
        check_eq("clr_busy",     TW'(shadow_busy), TW'(0));
        check_eq("clr_tv",       TW'(trim_valid),  TW'(0));
        check_eq("clr_trim",     trim_data,        '0);
        tick();
        check_eq("clr_lost_byte", TW'(load_cnt),   TW'(0));
        fill_zero();
        run_load("postclr", 32, 1'b0);

        // Asynchronous reset in the middle of a load.
        fill_ramp(8'hBA);
        for (int i = 0; i < 16; i++) send_byte(stim[i], 1'b0);
        check_eq("prerst_busy", TW'(shadow_busy), TW'(1));
        #2;
        rst = 1'b1;
        #1;
        clear_model();
        check_eq("arst_load_cnt", TW'(load_cnt),    TW'(0));
        check_eq("arst_busy",     TW'(shadow_busy), TW'(0));
        check_eq("arst_tv",       TW'(trim_valid),  TW'(0));
        check_eq("arst_trim",     trim_data,        '0);
        tick();
        rst = 1'b0;
        tick();
        run_load("lastdone", 32, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
